// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the operand-read stage, seq_alu and write-back.
// The master side presents operations and consumes results; the slave side is the ALU.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       aluOp;
  logic             Ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_hi;
  logic             Zero;
  logic             Neg;
  logic             Carry;
  logic             Ovf;
  logic             DivZero;

  modport master (
    output in_valid, A, B, aluOp, Ci, out_ready,
    input  in_ready, out_valid, Y, Y_hi, Zero, Neg, Carry, Ovf, DivZero
  );

  modport slave (
    input  in_valid, A, B, aluOp, Ci, out_ready,
    output in_ready, out_valid, Y, Y_hi, Zero, Neg, Carry, Ovf, DivZero
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops finish in one cycle; MUL/DIV/MOD iterate over WIDTH cycles.
// Results and flags are registered and held in DONE until the consumer accepts them.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [3:0] OpMul = 4'd13;
  localparam logic [3:0] OpDiv = 4'd14;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] y_q, y_d, y_hi_q, y_hi_d;
  logic [3:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

  logic             cin, sc_carry, sc_ovf, last, div_ge;
  logic [WIDTH:0]   sum, diff, mul_sum, div_rem;
  logic [WIDTH-1:0] sc_y, swapn, div_sub;

  // Single-cycle datapath works straight off the bus operands at accept.
  always_comb begin
    cin  = bus.aluOp[4] & bus.Ci;
    sum  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cin};
    diff = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, cin};
    swapn = '0;
    for (int i = 0; i < int'(WIDTH / 8); i++) begin
      swapn[8*i +: 8] = {bus.A[8*i +: 4], bus.A[8*i+4 +: 4]};
    end
    sc_y     = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (bus.aluOp[3:0])
      4'd0:  sc_y = bus.B;
      4'd1: begin
        sc_y     = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd2: begin
        sc_y     = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd3:  sc_y = bus.A & bus.B;
      4'd4:  sc_y = bus.A | bus.B;
      4'd5:  sc_y = bus.A ^ bus.B;
      4'd6:  sc_y = ~bus.A;
      4'd7: begin
        sc_y   = -bus.A;
        sc_ovf = (bus.A == {1'b1, {(WIDTH-1){1'b0}}});
      end
      4'd8: begin
        sc_y     = {bus.A[WIDTH-2:0], cin};
        sc_carry = bus.A[WIDTH-1];
      end
      4'd9: begin
        sc_y     = {cin, bus.A[WIDTH-1:1]};
        sc_carry = bus.A[0];
      end
      4'd10: begin
        sc_y     = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
        sc_carry = bus.A[0];
      end
      4'd11: sc_y = {bus.A[WIDTH/2-1:0], bus.A[WIDTH-1:WIDTH/2]};
      4'd12: sc_y = swapn;
      default: sc_y = '0;
    endcase
  end

  // hi/lo double as {product high, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    last    = (cnt_q == CntW'(WIDTH - 1));
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_rem = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_rem >= {1'b0, b_q});
    div_sub = div_rem[WIDTH-1:0] - b_q;
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          b_d   = bus.B;
          op_d  = bus.aluOp[3:0];
          hi_d  = '0;
          lo_d  = bus.A;
          cnt_d = '0;
          if (bus.aluOp[3:0] == OpMul) begin
            state_d = StMul;
          end else if (bus.aluOp[3:0] >= OpDiv) begin
            state_d = StDiv;
          end else begin
            state_d = StDone;
            y_d     = sc_y;
            y_hi_d  = '0;
            carry_d = sc_carry;
            ovf_d   = sc_ovf;
            dz_d    = 1'b0;
          end
        end
      end
      StMul: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          y_d     = lo_d;
          y_hi_d  = hi_d;
          carry_d = |hi_d;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      StDiv: begin
        // B == 0 naturally yields quotient all-ones and remainder A.
        hi_d  = div_ge ? div_sub : div_rem[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          y_d     = (op_q == OpDiv) ? lo_d : hi_d;
          y_hi_d  = (op_q == OpDiv) ? hi_d : lo_d;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = (b_q == '0);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_hi_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.Y         = y_q;
  assign bus.Y_hi      = y_hi_q;
  assign bus.Zero      = (y_q == '0);
  assign bus.Neg       = y_q[WIDTH-1];
  assign bus.Carry     = carry_q;
  assign bus.Ovf       = ovf_q;
  assign bus.DivZero   = dz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16: hand-computed vectors for single-cycle ops,
// iterative MUL/DIV/MOD, divide by zero, backpressure and reset abort.
module tb_seq_alu;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  bit   rdy_seen;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, accept it, then wait (bounded) for out_valid; lat counts cycles after accept.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                       input logic ci);
    bus.A        = a;
    bus.B        = b;
    bus.aluOp    = op;
    bus.Ci       = ci;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    lat          = 1;
    rdy_seen     = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("back_to_idle", 32'(bus.in_ready), 32'd1);
    chk("valid_dropped", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.aluOp     = '0;
    bus.Ci        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_y", 32'(bus.Y), 32'h0);
    chk("rst_y_hi", 32'(bus.Y_hi), 32'h0);
    chk("rst_flags", {27'd0, bus.Zero, bus.Neg, bus.Carry, bus.Ovf, bus.DivZero}, 32'b10000);

    // ADD with carry-in: 0xFFFF + 1 + 1
    issue(16'hFFFF, 16'h0001, 5'h11, 1'b1);
    chk("add_lat", 32'(lat), 32'd1);
    chk("add_y", 32'(bus.Y), 32'h0001);
    chk("add_flags", {29'd0, bus.Zero, bus.Carry, bus.Ovf}, 32'b010);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    release_op();

    issue(16'h8000, 16'h0001, 5'h02, 1'b0);
    chk("sub_y", 32'(bus.Y), 32'h7FFF);
    chk("sub_flags", {30'd0, bus.Carry, bus.Ovf}, 32'b01);
    release_op();

    issue(16'h0001, 16'h0002, 5'h02, 1'b0);
    chk("sub_borrow_y", 32'(bus.Y), 32'hFFFF);
    chk("sub_borrow_flags", {29'd0, bus.Neg, bus.Carry, bus.Ovf}, 32'b110);
    release_op();

    issue(16'h8003, 16'h0000, 5'h0A, 1'b0);
    chk("asr_y", 32'(bus.Y), 32'hC001);
    chk("asr_flags", {30'd0, bus.Carry, bus.Neg}, 32'b11);
    release_op();

    issue(16'h8001, 16'h0000, 5'h18, 1'b1);
    chk("lsl_y", 32'(bus.Y), 32'h0003);
    chk("lsl_carry", 32'(bus.Carry), 32'd1);
    release_op();

    issue(16'h8000, 16'h0000, 5'h07, 1'b0);
    chk("neg_y", 32'(bus.Y), 32'h8000);
    chk("neg_ovf", 32'(bus.Ovf), 32'd1);
    release_op();

    issue(16'h1234, 16'h0000, 5'h0B, 1'b0);
    chk("swap_y", 32'(bus.Y), 32'h3412);
    release_op();

    issue(16'h1234, 16'h0000, 5'h0C, 1'b0);
    chk("swapn_y", 32'(bus.Y), 32'h2143);
    release_op();

    issue(16'hF0F0, 16'h0F0F, 5'h03, 1'b0);
    chk("and_zero", {30'd0, bus.Zero, bus.Carry}, 32'b10);
    release_op();

    issue(16'h1234, 16'h0100, 5'h0D, 1'b0);
    chk("mul_lat", 32'(lat), 32'd17);
    chk("mul_in_ready_low", 32'(rdy_seen), 32'd0);
    chk("mul_y", 32'(bus.Y), 32'h3400);
    chk("mul_y_hi", 32'(bus.Y_hi), 32'h0012);
    chk("mul_carry", 32'(bus.Carry), 32'd1);
    release_op();

    issue(16'd100, 16'd7, 5'h0E, 1'b0);
    chk("div_lat", 32'(lat), 32'd17);
    chk("div_y", 32'(bus.Y), 32'd14);
    chk("div_y_hi", 32'(bus.Y_hi), 32'd2);
    chk("div_dz", 32'(bus.DivZero), 32'd0);
    release_op();

    issue(16'd100, 16'd7, 5'h0F, 1'b0);
    chk("mod_y", 32'(bus.Y), 32'd2);
    chk("mod_y_hi", 32'(bus.Y_hi), 32'd14);
    release_op();

    issue(16'h00AB, 16'h0000, 5'h0E, 1'b0);
    chk("div0_lat", 32'(lat), 32'd17);
    chk("div0_y", 32'(bus.Y), 32'hFFFF);
    chk("div0_y_hi", 32'(bus.Y_hi), 32'h00AB);
    chk("div0_dz", 32'(bus.DivZero), 32'd1);
    release_op();

    // Backpressure: XOR result must hold for 5 cycles with out_ready low.
    issue(16'hF0F0, 16'h0FF0, 5'h05, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_y", 32'(bus.Y), 32'hFF00);
      chk("bp_state", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
      tick();
    end
    chk("bp_flags", {28'd0, bus.Neg, bus.Zero, bus.Carry, bus.Ovf}, 32'b1000);
    release_op();
    issue(16'h0005, 16'h0000, 5'h06, 1'b0);
    chk("post_bp_not", 32'(bus.Y), 32'hFFFA);
    release_op();

    // Abort a MUL mid-iteration with reset.
    bus.A        = 16'h1234;
    bus.B        = 16'h0100;
    bus.aluOp    = 5'h0D;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_y", 32'(bus.Y), 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) break;
      tick();
    end
    chk("abort_no_result", 32'(bus.out_valid), 32'd0);
    issue(16'h0002, 16'h0003, 5'h01, 1'b0);
    chk("after_abort_lat", 32'(lat), 32'd1);
    chk("after_abort_add", 32'(bus.Y), 32'h0005);
    release_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Executes one operation per transaction:
  - single-cycle ops (logic, add/sub, shifts, swaps) complete in 1 cycle.
  - MUL, DIV and MOD run iteratively over WIDTH cycles.
- Result and flags are registered and held until the consumer accepts them.
- Sits between the register-file read stage and write-back; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, datapath width; must be a multiple of 8 and at least 8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- aluOp  in  5  [3:0] operation code; [4] enables carry-in use.
- Ci  in  1  carry-in.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts result.
- Y  out  WIDTH  primary result.
- Y_hi  out  WIDTH  secondary result (MUL high half, DIV remainder, MOD quotient); 0 otherwise.
- Zero  out  1  Y == 0.
- Neg  out  1  Y[WIDTH-1].
- Carry  out  1  carry/borrow/shift-out.
- Ovf  out  1  signed overflow.
- DivZero  out  1  DIV/MOD with B == 0.

Behaviour:
- Reset:
  - state IDLE.
  - out_valid=0; Y, Y_hi, Carry, Ovf, DivZero = 0.
  - Zero/Neg derive from the registered Y.
  - rst mid-operation aborts it; no out_valid is produced.
- in_ready = (state == IDLE), combinational from state.
- Accept occurs on a cycle with in_valid && in_ready. A, B, aluOp and Ci are captured into internal registers at accept.
- States and transitions:
  - IDLE: accept → MUL for op 13, DIV for op 14/15, else DONE with the result computed from the captured inputs (out_valid in the next cycle).
  - MUL: shift-add over WIDTH iterations using a counter, then → DONE.
  - DIV: restoring division over WIDTH iterations, then → DONE.
  - DONE: out_valid=1; Y/Y_hi/flags stable. On out_ready → IDLE.
- No accept occurs while in DONE.
- Latency (accept cycle t):
  - single-cycle ops: out_valid at t+1.
  - MUL/DIV/MOD: out_valid at t+WIDTH+1.
- Effective carry-in is cin = aluOp[4] & Ci.
- Ops:
  - 0 B: Y=B.
  - 1 ADD: Y=A+B+cin; Carry=bit WIDTH of the sum; Ovf=signed overflow.
  - 2 SUB: Y=A-B-cin; Carry=1 iff unsigned borrow (A < B+cin); Ovf=signed overflow.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT: Y=~A.
  - 7 NEG: Y=-A; Ovf=1 iff A==100..0.
  - 8 LSL: Y={A[W-2:0],cin}; Carry=A[W-1].
  - 9 LSR: Y={cin,A[W-1:1]}; Carry=A[0].
  - 10 ASR: Y={A[W-1],A[W-1:1]}; Carry=A[0].
  - 11 SWAP: exchange upper and lower halves.
  - 12 SWAPN: swap the two nibbles within every byte.
  - 13 MUL: unsigned; {Y_hi,Y}=A*B; Carry=(Y_hi!=0).
  - 14 DIV: unsigned; Y=A/B, Y_hi=A%B.
  - 15 MOD: Y=A%B, Y_hi=A/B.
- Carry and Ovf are 0 for any op not listed above as setting them.
- Divide by zero: quotient = all ones, remainder = A, DivZero=1; still takes WIDTH cycles.
- Flags are valid only while out_valid; they are held unchanged from entering DONE until leaving it.

Test Plan:
- Reset then ADD, WIDTH=16: A=0xFFFF, B=0x0001, aluOp=0x11, Ci=1 → out_valid one cycle after accept; Y=0x0001, Carry=1, Zero=0, Ovf=0.
- SUB: A=0x8000, B=0x0001, aluOp=0x02 → Y=0x7FFF, Ovf=1, Carry=0. ASR on A=0x8003 → Y=0xC001, Carry=1, Neg=1.
- MUL: A=0x1234, B=0x0100 → out_valid exactly 17 cycles after accept; Y=0x3400, Y_hi=0x0012, Carry=1. in_ready stays low throughout.
- DIV then MOD with A=100, B=7 → Y=14, Y_hi=2, then Y=2, Y_hi=14. DIV with B=0, A=0x00AB → Y=0xFFFF, Y_hi=0x00AB, DivZero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Y/flags stable, in_ready=0. Pulse out_ready → IDLE next cycle, new accept allowed.
- Assert rst at iteration 5 of MUL → next cycle IDLE, out_valid=0, Y=0. A following ADD completes normally.
